// File: rtl/apb_mem_slave_p.sv
// rtl/apb_mem_slave_p.sv - parametrised APB3 memory slave with wait states, byte strobes and error response
module apb_mem_slave_p #(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          DEPTH       = 64,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
  parameter int unsigned          WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int unsigned       BYTES   = DATA_W / 8;
  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]    strb_q, strb_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]   dec_addr;
  logic                dec_wr;
  logic [ADDR_W-1:0]   dec_off;
  logic [ADDR_W-1:0]   dec_word;
  logic                dec_err;
  logic [IDX_W-1:0]    dec_idx;
  logic                load_resp;
  logic                mem_we;

  // Decode the live bus in IDLE (zero-wait response is formed on the setup edge), else the latched copy
  always_comb begin
    dec_addr = (state_q == S_IDLE) ? PADDR : addr_q;
    dec_wr   = (state_q == S_IDLE) ? PWRITE : wr_q;
    dec_off  = dec_addr - BASE_ADDR;
    dec_word = dec_off / BYTES_A;
    dec_err  = (dec_addr < BASE_ADDR) || (dec_word >= DEPTH_A) || ((dec_off % BYTES_A) != '0);
    dec_idx  = dec_word[IDX_W-1:0];
  end

  // Next-state, wait counter and response formation
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    load_resp = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_ACCESS;
          if (WAIT_STATES == 0) begin
            load_resp = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (!(PSEL && PENABLE)) begin
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          cnt_d     = '0;
        end else if (pready_q) begin
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          mem_we    = wr_q && !dec_err;
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          load_resp = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_resp) begin
      pready_d  = 1'b1;
      pslverr_d = dec_err;
      if (!dec_wr) begin
        prdata_d = dec_err ? '0 : mem_q[dec_idx];
      end
    end
  end

  // Control and response registers; reset aborts any transfer in flight
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Storage array is never cleared; byte lanes commit only on a clean completion edge
  always_ff @(posedge PCLK) begin
    if (PRESETn && mem_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (strb_q[i]) begin
          mem_q[dec_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// tb/tb_apb_mem_slave_p.sv - self-checking bench for apb_mem_slave_p across three configurations
module tb_apb_mem_slave_p;

  logic        clk = 1'b0;
  logic        prst_n;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_w [3];
  logic        pready_w [3];
  logic        pslverr_w [3];

  int          n_assert = 0;
  int          n_fail = 0;

  int          ws [3] = '{0, 3, 2};
  logic [31:0] base [3] = '{32'h0, 32'h0, 32'h100};
  logic [31:0] mdl [3][64];

  always #5 clk = ~clk;

  apb_mem_slave_p u_a (
    .PCLK(clk), .PRESETn(prst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_w[0]), .PREADY(pready_w[0]), .PSLVERR(pslverr_w[0])
  );

  apb_mem_slave_p #(.WAIT_STATES(3)) u_b (
    .PCLK(clk), .PRESETn(prst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_w[1]), .PREADY(pready_w[1]), .PSLVERR(pslverr_w[1])
  );

  apb_mem_slave_p #(.BASE_ADDR(32'h100), .WAIT_STATES(2)) u_c (
    .PCLK(clk), .PRESETn(prst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_w[2]), .PREADY(pready_w[2]), .PSLVERR(pslverr_w[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input int k, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - base[k];
    return (addr < base[k]) || (off % 4 != 0) || (off / 4 >= 64);
  endfunction

  function automatic int exp_idx(input int k, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - base[k];
    return int'(off / 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; called 1 time unit after a rising edge, returns likewise
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    int  n;
    bit  e;
    int  ix;
    e  = exp_err(k, addr);
    ix = exp_idx(k, addr);
    psel    = 3'b000;
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    tick();
    penable = 1'b1;
    pwrite  = ~wr;
    paddr   = $urandom;
    pwdata  = $urandom;
    pstrb   = 4'($urandom);
    n = 1;
    while (pready_w[k] !== 1'b1 && n < 40) begin
      check("pslverr_wait", 64'(pslverr_w[k]), 64'd0);
      tick();
      n++;
    end
    check("ready_latency", 64'(n), 64'(ws[k] + 1));
    check("pslverr", 64'(pslverr_w[k]), 64'(e));
    if (!wr) begin
      check("prdata", 64'(prdata_w[k]), e ? 64'd0 : 64'(mdl[k][ix]));
    end else if (!e) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mdl[k][ix][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    tick();
    psel    = 3'b000;
    penable = 1'b0;
    check("ready_single", 64'(pready_w[k]), 64'd0);
    check("pslverr_clear", 64'(pslverr_w[k]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] old;
    logic [31:0] a;
    int          k;

    prst_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_pready", 64'(pready_w[i]), 64'd0);
      check("rst_pslverr", 64'(pslverr_w[i]), 64'd0);
      check("rst_prdata", 64'(prdata_w[i]), 64'd0);
    end
    prst_n = 1'b1;
    tick();

    // Preload every word so the model knows all contents
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 64; j++) begin
        xfer(i, 1'b1, base[i] + 32'(4*j), $urandom | 32'h1, 4'hF);
      end
    end

    // Default config: full write then read
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0);
    check("deadbeef", 64'(prdata_w[0]), 64'h0000_0000_DEAD_BEEF);

    // Wait states: preload then read word 0
    xfer(1, 1'b1, 32'h00, 32'h12345678, 4'hF);
    xfer(1, 1'b0, 32'h00, 32'h0, 4'h0);
    check("ws3_read", 64'(prdata_w[1]), 64'h0000_0000_1234_5678);

    // Byte strobes
    xfer(0, 1'b1, 32'h10, 32'h00000000, 4'hF);
    xfer(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
    check("strobe_merge", 64'(prdata_w[0]), 64'h0000_0000_00BB_00DD);

    // Back-to-back writes, no idle cycle between them
    xfer(0, 1'b1, 32'h0, 32'h11112222, 4'hF);
    xfer(0, 1'b1, 32'h4, 32'h33334444, 4'hF);
    xfer(0, 1'b1, 32'h8, 32'h55556666, 4'hF);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0);

    // Error decode on the offset instance
    xfer(2, 1'b1, 32'hFC,  $urandom, 4'hF);
    xfer(2, 1'b1, 32'h200, $urandom, 4'hF);
    xfer(2, 1'b1, 32'h102, $urandom, 4'hF);
    xfer(2, 1'b0, 32'hFC,  32'h0, 4'h0);
    xfer(2, 1'b0, 32'h200, 32'h0, 4'h0);
    xfer(2, 1'b0, 32'h102, 32'h0, 4'h0);
    xfer(2, 1'b0, 32'h100, 32'h0, 4'h0);
    xfer(2, 1'b1, 32'h1FC, 32'hCAFEF00D, 4'hF);
    xfer(2, 1'b0, 32'h1FC, 32'h0, 4'h0);

    // Reset in the middle of a write access
    old = mdl[2][1];
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h104; pwdata = ~old; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    prst_n = 1'b0;
    tick();
    check("abort_rst_pready", 64'(pready_w[2]), 64'd0);
    check("abort_rst_pslverr", 64'(pslverr_w[2]), 64'd0);
    check("abort_rst_prdata", 64'(prdata_w[2]), 64'd0);
    prst_n = 1'b1; psel = 3'b000; penable = 1'b0;
    tick();
    xfer(2, 1'b0, 32'h104, 32'h0, 4'h0);

    // PSEL dropped in the middle of a write access
    old = mdl[2][2];
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h108; pwdata = ~old; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    psel = 3'b000; penable = 1'b0;
    tick();
    check("abort_sel_pready", 64'(pready_w[2]), 64'd0);
    check("abort_sel_pslverr", 64'(pslverr_w[2]), 64'd0);
    xfer(2, 1'b0, 32'h108, 32'h0, 4'h0);

    // PENABLE high while idle must not start a transfer
    psel = 3'b111; penable = 1'b1; pwrite = 1'b0; paddr = 32'h100;
    repeat (3) begin
      tick();
      for (int i = 0; i < 3; i++) check("idle_penable", 64'(pready_w[i]), 64'd0);
    end
    psel = 3'b000; penable = 1'b0;
    tick();

    // Randomised traffic against the model
    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) a = base[k] - 32'd8 + 32'($urandom_range(0, 280));
      else a = base[k] + 32'(4 * $urandom_range(0, 63));
      xfer(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Final sweep of every word
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 64; j++) begin
        xfer(i, 1'b0, base[i] + 32'(4*j), 32'h0, 4'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave_p.md
Name: apb_mem_slave_p

Overview:
- Parametrised APB3 memory-mapped slave; successor to the fixed 32x64 APB slave memory.
- Adds configurable data width, depth and base address, plus programmable wait states, PSTRB byte-lane writes and PSLVERR on bad addresses.
- All outputs are registered.
- Sits behind the APB master/decoder alongside the GPIO and UART slaves; one PSEL per instance.

Parameters:
- DATA_W, 32, data bus width; must be a multiple of 8.
- ADDR_W, 32, PADDR width.
- DEPTH, 64, number of DATA_W-bit words.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_W/8.
- WAIT_STATES, 0, extra access cycles with PREADY=0 before completion; range 0..15.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  synchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte-lane write enables.
- PRDATA  out  DATA_W  read data; valid while PREADY=1.
- PREADY  out  1  transfer completes in this cycle.
- PSLVERR  out  1  error response; valid while PREADY=1.

Behaviour:
- Reset (PRESETn=0 at a rising edge):
  - state=IDLE; PREADY=0, PSLVERR=0, PRDATA=0; wait counter cleared.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts it; a pending write is not committed.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On an edge sampling PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE, PWDATA and PSTRB, then go to ACCESS.
  - The latched values are used for the whole transfer; later changes on those inputs are ignored.
- Counter load:
  - On entering ACCESS, cnt = WAIT_STATES.
  - If WAIT_STATES=0, set PREADY=1 on that same edge.
- ACCESS, while PSEL=1 and PENABLE=1:
  - If PREADY=0 and cnt>1: cnt decrements.
  - If PREADY=0 and cnt=1: set PREADY=1.
  - Net effect: PREADY is high in exactly the (WAIT_STATES+1)th access cycle, for one cycle only.
- Completion edge (sampling PSEL&PENABLE&PREADY):
  - Commit the write, if any.
  - Clear PREADY and PSLVERR. PRDATA holds its value.
  - Return to IDLE.
  - A new setup phase may be sampled on the very next edge (back-to-back transfers, no idle cycle needed).
- Address decode:
  - off = latched PADDR - BASE_ADDR, computed at ADDR_W bits unsigned.
  - idx = off / (DATA_W/8).
  - Error if PADDR < BASE_ADDR, idx >= DEPTH, or off is not aligned to DATA_W/8.
- Read:
  - PRDATA = mem[idx], loaded on the edge that sets PREADY.
  - On error, PRDATA=0 and PSLVERR=1.
- Write:
  - On the completion edge, for each lane i with PSTRB[i]=1, mem[idx][8i+7:8i] = PWDATA lane i.
  - On error, nothing is written and PSLVERR=1.
  - PSTRB=0 is a legal no-op write with no error.
- PSLVERR is asserted together with PREADY (same edge) and is 0 at all other times.
- Protocol violation: PSEL or PENABLE drops in ACCESS before completion. Abort, no write, PREADY=0, PSLVERR=0, return to IDLE.
- PENABLE=1 sampled while in IDLE is ignored; no transfer starts.

Test Plan:
- Defaults, write 0xDEADBEEF to 0x08 with PSTRB=4'hF, then read 0x08:
  - PREADY high in the first access cycle of each transfer.
  - Read returns PRDATA=0xDEADBEEF; PSLVERR=0 throughout.
- WAIT_STATES=3, read 0x00 after preloading 0x12345678:
  - PREADY=0 for 3 access cycles, high in the 4th.
  - PRDATA=0x12345678 in that 4th cycle.
- Byte strobes:
  - Preload 0x00000000 at 0x10, write 0xAABBCCDD with PSTRB=4'b0101, read back.
  - Read returns 0x00BB00DD.
- Errors (BASE_ADDR=0x100, DEPTH=64):
  - Accesses to 0xFC, 0x200 and 0x102: PSLVERR=1 with PREADY.
  - Reads return PRDATA=0; memory is unchanged.
  - Access to 0x1FC succeeds with PSLVERR=0.
- Back-to-back writes to 0x0, 0x4, 0x8 with no idle cycle between transfers:
  - Each completes in 2 cycles (setup + 1 access).
  - Read-back returns all three values.
- Aborts, each during an access phase with WAIT_STATES=2:
  - Assert PRESETn=0 mid-access: PREADY, PSLVERR and PRDATA all 0 after the edge; the target word keeps its old value.
  - Drop PSEL mid-write: no write occurs and the FSM is back in IDLE.
